// File: rtl/sys_bus_arbiter_if.sv
// System bus bundle: two master command ports and the shared slave port.
// The arbiter attaches through "slave"; masters and the slave model through "master".
interface sys_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_wdata;
  logic [2:0]    m0_op;
  logic          m0_lock;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_wdata;
  logic [2:0]    m1_op;
  logic          m1_lock;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          s_req;
  logic          s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdata;
  logic [2:0]    s_op;
  logic          s_ready;
  logic [DW-1:0] s_rdata;

  logic          lock_err;

  modport slave (
    input  m0_req, m0_we, m0_adr, m0_wdata, m0_op, m0_lock,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_adr, m1_wdata, m1_op, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata,
    output s_req, s_we, s_adr, s_wdata, s_op,
    input  s_ready, s_rdata,
    output lock_err
  );

  modport master (
    output m0_req, m0_we, m0_adr, m0_wdata, m0_op, m0_lock,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_adr, m1_wdata, m1_op, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  s_req, s_we, s_adr, s_wdata, s_op,
    output s_ready, s_rdata,
    input  lock_err
  );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Two-master system bus arbiter: fixed priority to master 0, starvation
// guard for master 1, locked sequences with timeout, read-return routing.
module sys_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  sys_bus_arbiter_if.slave bus
);
  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);
  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  logic          lock_vld;
  logic          lock_own;
  logic [7:0]    lock_cnt;
  logic [7:0]    starve_cnt;
  logic          rd_pend;
  logic          rd_own;

  logic          force_rel;
  logic          locked;
  logic          starved;
  logic          sel;
  logic          lock_ok;
  logic          sel_req;
  logic          sel_we;
  logic          sel_lock;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_wdata;
  logic [2:0]    sel_op;
  logic          acc;

  // A timed-out lock is dropped in the same cycle it expires
  assign force_rel = lock_vld && (lock_cnt == LOCK_LIM);
  assign locked    = lock_vld && !force_rel;
  assign starved   = (starve_cnt == WAIT_LIM) && bus.m1_req;

  always_comb begin
    sel = 1'b0;
    priority case (1'b1)
      locked:     sel = lock_own && bus.m1_req;
      starved:    sel = 1'b1;
      bus.m0_req: sel = 1'b0;
      bus.m1_req: sel = 1'b1;
      default:    sel = 1'b0;
    endcase
  end

  // Idle owner keeps master 0 fields on the bus but must not let it through
  assign lock_ok   = !locked || (sel == lock_own);

  assign sel_req   = sel ? bus.m1_req   : bus.m0_req;
  assign sel_we    = sel ? bus.m1_we    : bus.m0_we;
  assign sel_lock  = sel ? bus.m1_lock  : bus.m0_lock;
  assign sel_adr   = sel ? bus.m1_adr   : bus.m0_adr;
  assign sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
  assign sel_op    = sel ? bus.m1_op    : bus.m0_op;

  assign bus.s_req   = !rst && lock_ok && sel_req;
  assign bus.s_we    = sel_we;
  assign bus.s_adr   = sel_adr;
  assign bus.s_wdata = sel_wdata;
  assign bus.s_op    = sel_op;

  assign acc        = bus.s_req && bus.s_ready;
  assign bus.m0_gnt = acc && !sel;
  assign bus.m1_gnt = acc && sel;

  assign bus.m0_rvalid = !rst && rd_pend && !rd_own;
  assign bus.m1_rvalid = !rst && rd_pend && rd_own;
  assign bus.m0_rdata  = bus.s_rdata;
  assign bus.m1_rdata  = bus.s_rdata;

  assign bus.lock_err = !rst && force_rel;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld   <= 1'b0;
      lock_own   <= 1'b0;
      lock_cnt   <= '0;
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
      rd_own     <= 1'b0;
    end else begin
      rd_pend <= acc && !sel_we;
      if (acc) rd_own <= sel;

      if (!bus.m1_req || bus.m1_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != WAIT_LIM)
        starve_cnt <= starve_cnt + 8'd1;

      if (acc && sel_lock) begin
        lock_vld <= 1'b1;
        lock_own <= sel;
        lock_cnt <= '0;
      end else if (force_rel || (acc && locked)) begin
        lock_vld <= 1'b0;
        lock_cnt <= '0;
      end else if (lock_vld) begin
        lock_cnt <= lock_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: directed vector table, corner sequences,
// and random traffic against a rule-level reference model.
module tb_sys_bus_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 8;
  localparam int LOCK_MAX = 16;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sys_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sys_bus_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit rst, r0, r1, we0, we1, lk0, lk1, rdy;
    bit g0, g1, sreq, v0, v1;
  } vec_t;

  vec_t tbl [21];

  int checks = 0;
  int errors = 0;

  bit            rs;
  bit            r   [2];
  bit            we  [2];
  bit            lk  [2];
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wd  [2];
  logic [2:0]    op  [2];
  bit            rdy;
  logic [DW-1:0] srd;

  int lk_own = -1;
  int lk_age = 0;
  int wait1  = 0;
  int rd_who = -1;

  int win;
  int acc_m;
  bit e_err;

  bit            o_g  [2];
  bit            o_v  [2];
  bit            o_err;
  logic [DW-1:0] o_rd [2];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_eval();
    int own;
    e_err = !rs && lk_own >= 0 && lk_age == LOCK_MAX;
    own   = e_err ? -1 : lk_own;
    win   = -1;
    if (rs) win = -1;
    else if (own >= 0) win = r[own] ? own : -1;
    else if (r[1] && wait1 >= MAX_WAIT) win = 1;
    else if (r[0]) win = 0;
    else if (r[1]) win = 1;
    acc_m = (win >= 0 && rdy) ? win : -1;
  endtask

  task automatic model_update();
    if (rs) begin
      lk_own = -1;
      lk_age = 0;
      wait1  = 0;
      rd_who = -1;
      return;
    end
    rd_who = (acc_m >= 0 && !we[acc_m]) ? acc_m : -1;
    if (!r[1] || acc_m == 1) wait1 = 0;
    else if (wait1 < MAX_WAIT) wait1++;
    if (acc_m >= 0 && lk[acc_m]) begin
      lk_own = acc_m;
      lk_age = 0;
    end else if (e_err || (acc_m >= 0 && acc_m == lk_own)) begin
      lk_own = -1;
      lk_age = 0;
    end else if (lk_own >= 0) begin
      lk_age++;
    end
  endtask

  task automatic cycle();
    int f;
    rst           = rs;
    bus.m0_req    = r[0];
    bus.m0_we     = we[0];
    bus.m0_lock   = lk[0];
    bus.m0_adr    = adr[0];
    bus.m0_wdata  = wd[0];
    bus.m0_op     = op[0];
    bus.m1_req    = r[1];
    bus.m1_we     = we[1];
    bus.m1_lock   = lk[1];
    bus.m1_adr    = adr[1];
    bus.m1_wdata  = wd[1];
    bus.m1_op     = op[1];
    bus.s_ready   = rdy;
    bus.s_rdata   = srd;
    #3;
    model_eval();
    o_g[0] = bus.m0_gnt;
    o_g[1] = bus.m1_gnt;
    o_v[0] = bus.m0_rvalid;
    o_v[1] = bus.m1_rvalid;
    o_err  = bus.lock_err;
    o_rd[0] = bus.m0_rdata;
    o_rd[1] = bus.m1_rdata;
    chk1("m0_gnt", bus.m0_gnt, acc_m == 0);
    chk1("m1_gnt", bus.m1_gnt, acc_m == 1);
    chk1("s_req", bus.s_req, win >= 0);
    chk1("m0_rvalid", bus.m0_rvalid, !rs && rd_who == 0);
    chk1("m1_rvalid", bus.m1_rvalid, !rs && rd_who == 1);
    chk1("lock_err", bus.lock_err, e_err);
    if (!rs) begin
      f = (win >= 0) ? win : 0;
      chk1("s_we", bus.s_we, we[f]);
      chkw("s_adr", bus.s_adr, adr[f]);
      chkw("s_wdata", bus.s_wdata, wd[f]);
      chkw("s_op", 32'(bus.s_op), 32'(op[f]));
      if (rd_who == 0) chkw("m0_rdata", bus.m0_rdata, srd);
      if (rd_who == 1) chkw("m1_rdata", bus.m1_rdata, srd);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rs = 0; r[0] = 0; r[1] = 0; lk[0] = 0; lk[1] = 0; rdy = 1;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    adr[0] = 32'h0000_0100; adr[1] = 32'h0000_1000;
    wd[0]  = 32'h1111_0000; wd[1]  = 32'h2222_0000;
    op[0]  = 3'd2;          op[1]  = 3'd5;
    srd    = 32'hDEAD_BEEF;

    //               rst r0 r1 we0 we1 lk0 lk1 rdy  g0 g1 sreq v0 v1
    tbl[0]  = '{H, H, H, H, L, L, L, H,  L, L, L, L, L};
    tbl[1]  = '{H, H, H, H, L, L, L, H,  L, L, L, L, L};
    tbl[2]  = '{H, H, H, H, L, L, L, H,  L, L, L, L, L};
    tbl[3]  = '{L, H, H, H, L, L, L, H,  H, L, H, L, L};
    tbl[4]  = '{L, L, H, H, L, L, L, H,  L, H, H, L, L};
    tbl[5]  = '{L, H, L, L, L, L, L, H,  H, L, H, L, H};
    tbl[6]  = '{L, H, L, L, L, L, L, H,  H, L, H, H, L};
    tbl[7]  = '{L, H, L, L, L, L, L, H,  H, L, H, H, L};
    tbl[8]  = '{L, H, L, L, L, L, L, H,  H, L, H, H, L};
    tbl[9]  = '{L, L, L, L, L, L, L, H,  L, L, L, H, L};
    tbl[10] = '{L, L, L, L, L, L, L, H,  L, L, L, L, L};
    for (int i = 11; i < 16; i++)
      tbl[i] = '{L, H, L, H, L, L, L, L,  L, L, H, L, L};
    tbl[16] = '{L, H, L, H, L, L, L, H,  H, L, H, L, L};
    tbl[17] = '{L, L, L, L, L, L, L, H,  L, L, L, L, L};
    tbl[18] = '{L, H, L, L, L, L, L, H,  H, L, H, L, L};
    tbl[19] = '{H, L, L, L, L, L, L, H,  L, L, L, L, L};
    tbl[20] = '{L, L, L, L, L, L, L, H,  L, L, L, L, L};

    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      rs = tbl[i].rst; r[0] = tbl[i].r0; r[1] = tbl[i].r1;
      we[0] = tbl[i].we0; we[1] = tbl[i].we1;
      lk[0] = tbl[i].lk0; lk[1] = tbl[i].lk1; rdy = tbl[i].rdy;
      cycle();
      chk1($sformatf("tbl%0d_g0", i), o_g[0], tbl[i].g0);
      chk1($sformatf("tbl%0d_g1", i), o_g[1], tbl[i].g1);
      chk1($sformatf("tbl%0d_v0", i), o_v[0], tbl[i].v0);
      chk1($sformatf("tbl%0d_v1", i), o_v[1], tbl[i].v1);
      if (tbl[i].v1)
        chkw($sformatf("tbl%0d_rd1", i), o_rd[1], 32'hDEAD_BEEF);
    end

    // starvation: m1 wins on the ninth contested cycle
    idle();
    r[0] = 1; r[1] = 1; we[0] = 1; we[1] = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk1($sformatf("starve%0d_g0", i), o_g[0], i != 8);
      chk1($sformatf("starve%0d_g1", i), o_g[1], i == 8);
    end

    // m1 locked write, then unlocked read, m0 waiting
    idle();
    r[1] = 1; we[1] = 1; lk[1] = 1;
    cycle();
    chk1("lock_set_g1", o_g[1], 1'b1);
    r[1] = 0; lk[1] = 0; r[0] = 1; we[0] = 1;
    cycle();
    chk1("lock_hold_g0", o_g[0], 1'b0);
    r[1] = 1; we[1] = 0;
    cycle();
    chk1("lock_rel_g1", o_g[1], 1'b1);
    chk1("lock_rel_g0", o_g[0], 1'b0);
    r[1] = 0;
    cycle();
    chk1("lock_after_g0", o_g[0], 1'b1);
    chk1("lock_after_v1", o_v[1], 1'b1);

    // lock timeout with m1 blocked
    idle();
    r[0] = 1; we[0] = 1; lk[0] = 1; r[1] = 1; we[1] = 1;
    cycle();
    chk1("tmo_set_g0", o_g[0], 1'b1);
    r[0] = 0; lk[0] = 0;
    for (int i = 1; i <= 18; i++) begin
      cycle();
      chk1($sformatf("tmo%0d_g1", i), o_g[1], i == 17);
      chk1($sformatf("tmo%0d_err", i), o_err, i == 17);
      if (o_g[1]) r[1] = 0;
    end

    // m0 holds lock while m1 starves; m1 wins right after release
    idle();
    r[0] = 1; we[0] = 1; lk[0] = 1; r[1] = 1; we[1] = 1;
    for (int i = 0; i < 11; i++) begin
      cycle();
      chk1($sformatf("lkst%0d_g0", i), o_g[0], 1'b1);
    end
    lk[0] = 0;
    cycle();
    chk1("lkst_rel_g0", o_g[0], 1'b1);
    cycle();
    chk1("lkst_after_g1", o_g[1], 1'b1);
    idle();

    // random traffic, busy then sparse masters
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!r[m] && $urandom_range(9, 0) < ((c < 300) ? 5 : 1)) begin
          r[m]   = 1;
          we[m]  = 1'($urandom_range(1, 0));
          lk[m]  = $urandom_range(5, 0) == 0;
          adr[m] = $urandom;
          wd[m]  = $urandom;
          op[m]  = 3'($urandom_range(7, 0));
        end
      end
      rdy = $urandom_range(3, 0) != 0;
      srd = $urandom;
      cycle();
      for (int m = 0; m < 2; m++)
        if (acc_m == m) r[m] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
